// File: rtl/matmul_exec_unit.sv
// ============================================================================
// Module   : matmul_exec_unit
// Brief    : Sparse/dense multiply-accumulate execution unit with an
//            issue/result handshake (IDLE -> [EXEC] -> RESP).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_exec_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8,
    parameter int IDW   = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [3:0]      opcode_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [IDW-1:0]  id_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [XLEN-1:0] result_data_o,
    output logic [IDW-1:0]  result_id_o,
    output logic            result_we_o,
    output logic            result_err_o,
    output logic [7:0]      sparse_cnt_o
);

    localparam int         IW              = $clog2(DEPTH);
    localparam logic [3:0] OP_LOAD_DENSE   = 4'd1;
    localparam logic [3:0] OP_LOAD_SPARSE  = 4'd2;
    localparam logic [3:0] OP_RESET_ACC    = 4'd3;
    localparam logic [3:0] OP_STORE_ACC    = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [IW-1:0]   r_idx;
    logic [XLEN-1:0] r_acc;
    logic [7:0]      r_cnt;
    logic [XLEN-1:0] r_dense [DEPTH];
    logic [XLEN-1:0] r_res_data;
    logic [IDW-1:0]  r_res_id;
    logic            r_res_we;
    logic            r_res_err;

    logic [XLEN-1:0] w_prod;
    logic            w_unused_rs2;

    // Only the low XLEN bits of the product matter: accumulation is modulo 2^XLEN.
    assign w_prod       = r_rs1 * r_dense[r_idx];
    assign w_unused_rs2 = ^rs2_i[XLEN-1:IW];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_rs1      <= '0;
            r_idx      <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_id   <= '0;
            r_res_we   <= 1'b0;
            r_res_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dense[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (issue_valid_i) begin
                        r_op       <= opcode_i;
                        r_rs1      <= rs1_i;
                        r_idx      <= rs2_i[IW-1:0];
                        r_res_id   <= id_i;
                        r_res_data <= '0;
                        r_res_we   <= 1'b0;
                        r_res_err  <= 1'b0;
                        r_state    <= RESP;
                        case (opcode_i)
                            OP_LOAD_DENSE:  r_dense[rs2_i[IW-1:0]] <= rs1_i;
                            OP_LOAD_SPARSE: r_state <= EXEC;
                            OP_RESET_ACC: begin
                                r_acc <= '0;
                                r_cnt <= '0;
                            end
                            OP_STORE_ACC: begin
                                r_res_data <= r_acc;
                                r_res_we   <= 1'b1;
                            end
                            default:        r_res_err <= 1'b1;
                        endcase
                    end
                end
                EXEC: begin
                    if (r_op == OP_LOAD_SPARSE) begin
                        r_acc <= r_acc + w_prod;
                        if (r_cnt != 8'hFF) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (result_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign issue_ready_o  = (r_state == IDLE);
    assign result_valid_o = (r_state == RESP);
    assign result_data_o  = r_res_data;
    assign result_id_o    = r_res_id;
    assign result_we_o    = r_res_we;
    assign result_err_o   = r_res_err;
    assign sparse_cnt_o   = r_cnt;

endmodule

`default_nettype wire
